// File: rtl/wb_burst_master.sv
// Wishbone B3 master for single and incrementing-burst commands: CTI/BTE signalling,
// streamed write/read data, error termination and a strobe timeout.
module wb_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_n_i,
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic                              cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]             cmd_addr_i,
    input  logic [$clog2(MAX_BURST):0]        cmd_len_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    output logic [DATA_WIDTH-1:0]             rd_data_o,
    output logic                              rd_valid_o,
    output logic                              done_o,
    output logic                              err_o,
    output logic [ADDR_WIDTH-1:0]             m_wb_adr_o,
    output logic [DATA_WIDTH/8-1:0]           m_wb_sel_o,
    output logic                              m_wb_we_o,
    output logic [DATA_WIDTH-1:0]             m_wb_dat_o,
    input  logic [DATA_WIDTH-1:0]             m_wb_dat_i,
    output logic                              m_wb_cyc_o,
    output logic                              m_wb_stb_o,
    input  logic                              m_wb_ack_i,
    input  logic                              m_wb_err_i,
    output logic [2:0]                        m_wb_cti_o,
    output logic [1:0]                        m_wb_bte_o
);
    localparam int LEN_W = $clog2(MAX_BURST) + 1;
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(SEL_W);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0]      MAX_LEN  = LEN_W'(MAX_BURST);
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(SEL_W);
    localparam logic [ADDR_WIDTH-1:0] ADR_MASK = ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t                  state;
    logic [LEN_W-1:0]        len_r;
    logic [LEN_W-1:0]        rem_r;
    logic [LEN_W-1:0]        req_r;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    we_r;
    logic                    cyc_r;
    logic                    stb_r;
    logic [2:0]              cti_r;
    logic [ADDR_WIDTH-1:0]   adr_r;
    logic [DATA_WIDTH-1:0]   hold_r;
    logic [DATA_WIDTH-1:0]   rd_data_r;
    logic                    rd_valid_r;
    logic                    done_r;
    logic                    err_r;
    logic                    cmd_ready_r;

    logic beat_ok;
    logic abort;
    logic wr_fire;

    function automatic logic [2:0] beat_cti(input logic [LEN_W-1:0] len, input logic last);
        if (len == LEN_W'(1))
            return CTI_CLASSIC;
        return last ? CTI_END : CTI_INCR;
    endfunction

    // err wins over a simultaneous ack; timeout fires on the TIMEOUT-th unanswered strobe cycle
    assign beat_ok = stb_r & m_wb_ack_i & ~m_wb_err_i;
    assign abort   = stb_r & (m_wb_err_i | (~m_wb_ack_i & (tmo_cnt == TMO_LAST)));

    // For writes stb_r doubles as the hold-register valid flag
    assign wr_ready_o = (state == BURST) & we_r & (req_r < len_r) & (~stb_r | beat_ok);
    assign wr_fire    = wr_valid_i & wr_ready_o;

    assign cmd_ready_o = cmd_ready_r;
    assign rd_data_o   = rd_data_r;
    assign rd_valid_o  = rd_valid_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign m_wb_adr_o  = adr_r;
    assign m_wb_sel_o  = {SEL_W{stb_r}};
    assign m_wb_we_o   = we_r & cyc_r;
    assign m_wb_dat_o  = hold_r;
    assign m_wb_cyc_o  = cyc_r;
    assign m_wb_stb_o  = stb_r;
    assign m_wb_cti_o  = cti_r;
    assign m_wb_bte_o  = 2'b00;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            len_r       <= '0;
            rem_r       <= '0;
            req_r       <= '0;
            tmo_cnt     <= '0;
            we_r        <= 1'b0;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            cti_r       <= CTI_CLASSIC;
            adr_r       <= '0;
            hold_r      <= '0;
            rd_data_r   <= '0;
            rd_valid_r  <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_ready_r <= 1'b0;
                        we_r        <= cmd_we_i;
                        len_r       <= cmd_len_i;
                        rem_r       <= cmd_len_i;
                        req_r       <= '0;
                        tmo_cnt     <= '0;
                        adr_r       <= cmd_addr_i & ADR_MASK;
                        if (cmd_len_i == '0 || cmd_len_i > MAX_LEN) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end else begin
                            state <= BURST;
                            cyc_r <= 1'b1;
                            err_r <= 1'b0;
                            if (!cmd_we_i) begin
                                stb_r <= 1'b1;
                                cti_r <= beat_cti(cmd_len_i, cmd_len_i == LEN_W'(1));
                            end
                        end
                    end
                end
                BURST: begin
                    if (abort) begin
                        cyc_r  <= 1'b0;
                        stb_r  <= 1'b0;
                        cti_r  <= CTI_CLASSIC;
                        state  <= DONE;
                        done_r <= 1'b1;
                        err_r  <= 1'b1;
                    end else begin
                        if (beat_ok) begin
                            adr_r   <= adr_r + ADR_STEP;
                            rem_r   <= rem_r - LEN_W'(1);
                            tmo_cnt <= '0;
                            if (!we_r) begin
                                rd_data_r  <= m_wb_dat_i;
                                rd_valid_r <= 1'b1;
                            end
                        end else if (stb_r) begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end

                        if (beat_ok && rem_r == LEN_W'(1)) begin
                            cyc_r  <= 1'b0;
                            stb_r  <= 1'b0;
                            cti_r  <= CTI_CLASSIC;
                            state  <= DONE;
                            done_r <= 1'b1;
                            err_r  <= 1'b0;
                        end else if (!we_r) begin
                            if (beat_ok)
                                cti_r <= beat_cti(len_r, rem_r == LEN_W'(2));
                        end else if (wr_fire) begin
                            hold_r <= wr_data_i;
                            stb_r  <= 1'b1;
                            req_r  <= req_r + LEN_W'(1);
                            cti_r  <= beat_cti(len_r, (req_r + LEN_W'(1)) == len_r);
                        end else if (beat_ok) begin
                            stb_r <= 1'b0;
                            cti_r <= CTI_CLASSIC;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    err_r       <= 1'b0;
                    we_r        <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed testbench for wb_burst_master: reads, writes with wait states, error,
// timeout, illegal length and mid-burst reset, checked against hand-computed values.
module tb_wb_burst_master;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MB  = 16;
    localparam int TMO = 16;
    localparam int LW  = $clog2(MB) + 1;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_n_i = 1'b0;
    logic            cmd_valid_i = 1'b0;
    logic            cmd_ready_o;
    logic            cmd_we_i = 1'b0;
    logic [AW-1:0]   cmd_addr_i = '0;
    logic [LW-1:0]   cmd_len_i = '0;
    logic [DW-1:0]   wr_data_i = '0;
    logic            wr_valid_i = 1'b0;
    logic            wr_ready_o;
    logic [DW-1:0]   rd_data_o;
    logic            rd_valid_o;
    logic            done_o;
    logic            err_o;
    logic [AW-1:0]   m_wb_adr_o;
    logic [DW/8-1:0] m_wb_sel_o;
    logic            m_wb_we_o;
    logic [DW-1:0]   m_wb_dat_o;
    logic [DW-1:0]   m_wb_dat_i = '0;
    logic            m_wb_cyc_o;
    logic            m_wb_stb_o;
    logic            m_wb_ack_i = 1'b0;
    logic            m_wb_err_i = 1'b0;
    logic [2:0]      m_wb_cti_o;
    logic [1:0]      m_wb_bte_o;

    int checks   = 0;
    int failures = 0;

    wb_burst_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB), .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .done_o(done_o), .err_o(err_o),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o),
        .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i), .m_wb_cyc_o(m_wb_cyc_o),
        .m_wb_stb_o(m_wb_stb_o), .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
        .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one command for a single cycle; returns at the negedge after acceptance
    task automatic send_cmd(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready_o);
        end
        checks++;
        if ({m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, done_o, err_o, rd_valid_o, wr_ready_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, done_o, err_o, rd_valid_o, wr_ready_o});
        end
        checks++;
        if ({m_wb_adr_o, m_wb_cti_o, m_wb_bte_o, m_wb_sel_o} !== '0) begin
            failures++; $display("FAIL reset_bus got adr=%h cti=%b sel=%h exp=0", m_wb_adr_o, m_wb_cti_o, m_wb_sel_o);
        end
    endtask

    task automatic test_read_burst();
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic [2:0]  exp_cti;
        send_cmd(1'b0, 32'h100, LW'(4));
        checks++;
        if ({m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o} !== 7'b110_1111) begin
            failures++; $display("FAIL rd4_start got cyc/stb/we/sel=%b exp=1101111",
                                 {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o});
        end
        for (int i = 0; i < 4; i++) begin
            exp_adr = 32'h100 + 32'(4 * i);
            exp_cti = (i == 3) ? 3'b111 : 3'b010;
            exp_dat = 32'hA5A5_0000 + 32'(i);
            checks++;
            if (m_wb_adr_o !== exp_adr) begin
                failures++; $display("FAIL rd4_adr beat=%0d got=%h exp=%h", i, m_wb_adr_o, exp_adr);
            end
            checks++;
            if (m_wb_cti_o !== exp_cti) begin
                failures++; $display("FAIL rd4_cti beat=%0d got=%b exp=%b", i, m_wb_cti_o, exp_cti);
            end
            m_wb_ack_i = 1'b1;
            m_wb_dat_i = exp_dat;
            @(negedge wb_clk_i);
            checks++;
            if ({rd_valid_o, rd_data_o} !== {1'b1, exp_dat}) begin
                failures++; $display("FAIL rd4_data beat=%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid_o, rd_data_o, exp_dat);
            end
        end
        m_wb_ack_i = 1'b0;
        checks++;
        if ({done_o, err_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, cmd_ready_o} !== 8'b10_00_000_0) begin
            failures++; $display("FAIL rd4_done got done/err/cyc/stb/cti/rdy=%b exp=10000000",
                                 {done_o, err_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, cmd_ready_o});
        end
        @(negedge wb_clk_i);
        checks++;
        if ({done_o, rd_valid_o, cmd_ready_o} !== 3'b001) begin
            failures++; $display("FAIL rd4_idle got done/rdv/rdy=%b exp=001", {done_o, rd_valid_o, cmd_ready_o});
        end
    endtask

    task automatic test_write_single();
        send_cmd(1'b1, 32'h20, LW'(1));
        checks++;
        if ({m_wb_cyc_o, m_wb_stb_o, wr_ready_o} !== 3'b101) begin
            failures++; $display("FAIL wr1_wait got cyc/stb/wrdy=%b exp=101", {m_wb_cyc_o, m_wb_stb_o, wr_ready_o});
        end
        wr_valid_i = 1'b1;
        wr_data_i  = 32'hDEAD_BEEF;
        @(negedge wb_clk_i);
        wr_valid_i = 1'b0;
        checks++;
        if ({m_wb_stb_o, m_wb_we_o, m_wb_sel_o, m_wb_cti_o} !== 9'b1_1_1111_000) begin
            failures++; $display("FAIL wr1_ctrl got stb/we/sel/cti=%b exp=111111000",
                                 {m_wb_stb_o, m_wb_we_o, m_wb_sel_o, m_wb_cti_o});
        end
        checks++;
        if ({m_wb_adr_o, m_wb_dat_o} !== {32'h20, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL wr1_bus got adr=%h dat=%h exp adr=00000020 dat=deadbeef", m_wb_adr_o, m_wb_dat_o);
        end
        m_wb_ack_i = 1'b1;
        @(negedge wb_clk_i);
        m_wb_ack_i = 1'b0;
        checks++;
        if ({done_o, err_o, m_wb_cyc_o, m_wb_stb_o} !== 4'b1000) begin
            failures++; $display("FAIL wr1_done got done/err/cyc/stb=%b exp=1000", {done_o, err_o, m_wb_cyc_o, m_wb_stb_o});
        end
    endtask

    task automatic test_write_gap();
        logic [31:0] exp_dat;
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;
        int nb = 0, p = 0, gap_left = 0, gap_cyc = 0, budget = 0;
        bit started = 0, seen = 0, err_seen = 0;
        send_cmd(1'b1, 32'h400, LW'(8));
        while (!seen && budget < 60) begin
            budget++;
            if (done_o) begin
                seen = 1;
                err_seen = err_o;
            end else begin
                if (m_wb_stb_o) begin
                    started = 1;
                    exp_dat = 32'hC0DE_0000 + 32'(nb);
                    exp_adr = 32'h400 + 32'(4 * nb);
                    exp_cti = (nb == 7) ? 3'b111 : 3'b010;
                    checks++;
                    if ({m_wb_dat_o, m_wb_adr_o, m_wb_cti_o, m_wb_cyc_o} !== {exp_dat, exp_adr, exp_cti, 1'b1}) begin
                        failures++;
                        $display("FAIL wr8_beat n=%0d got dat=%h adr=%h cti=%b exp dat=%h adr=%h cti=%b",
                                 nb, m_wb_dat_o, m_wb_adr_o, m_wb_cti_o, exp_dat, exp_adr, exp_cti);
                    end
                    nb++;
                end else if (m_wb_cyc_o && started) begin
                    gap_cyc++;
                end
                m_wb_ack_i = m_wb_stb_o;
                if (p < 8 && gap_left == 0) begin
                    wr_valid_i = 1'b1;
                    wr_data_i  = 32'hC0DE_0000 + 32'(p);
                end else begin
                    wr_valid_i = 1'b0;
                    if (gap_left > 0) gap_left--;
                end
                #1;
                if (wr_valid_i && wr_ready_o) begin
                    p++;
                    if (p == 2) gap_left = 3;
                end
                @(negedge wb_clk_i);
            end
        end
        m_wb_ack_i = 1'b0;
        wr_valid_i = 1'b0;
        checks++;
        if ({seen, err_seen} !== 2'b10) begin
            failures++; $display("FAIL wr8_done got seen/err=%b exp=10", {seen, err_seen});
        end
        checks++;
        if (nb !== 8) begin
            failures++; $display("FAIL wr8_beats got=%0d exp=8", nb);
        end
        checks++;
        if (gap_cyc !== 3) begin
            failures++; $display("FAIL wr8_gap got=%0d exp=3", gap_cyc);
        end
    endtask

    task automatic test_read_err();
        int pulses = 0;
        send_cmd(1'b0, 32'h200, LW'(4));
        for (int i = 0; i < 3; i++) begin
            m_wb_ack_i = 1'b1;
            m_wb_err_i = (i == 2);
            m_wb_dat_i = 32'h0000_0011 * 32'(i + 1);
            @(negedge wb_clk_i);
            if (rd_valid_o) pulses++;
        end
        m_wb_ack_i = 1'b0;
        m_wb_err_i = 1'b0;
        checks++;
        if ({m_wb_cyc_o, m_wb_stb_o, done_o, err_o} !== 4'b0011) begin
            failures++; $display("FAIL rderr_abort got cyc/stb/done/err=%b exp=0011", {m_wb_cyc_o, m_wb_stb_o, done_o, err_o});
        end
        @(negedge wb_clk_i);
        if (rd_valid_o) pulses++;
        checks++;
        if (pulses !== 2) begin
            failures++; $display("FAIL rderr_pulses got=%0d exp=2", pulses);
        end
        checks++;
        if ({done_o, err_o} !== 2'b00) begin
            failures++; $display("FAIL rderr_pulse_len got done/err=%b exp=00", {done_o, err_o});
        end
    endtask

    task automatic test_timeout();
        int stb_cnt = 0;
        bit seen = 0, err_seen = 0, cyc_at_done = 1;
        send_cmd(1'b0, 32'h300, LW'(2));
        for (int c = 0; c < 40 && !seen; c++) begin
            if (done_o) begin
                seen = 1;
                err_seen = err_o;
                cyc_at_done = m_wb_cyc_o;
            end else begin
                if (m_wb_stb_o) stb_cnt++;
                @(negedge wb_clk_i);
            end
        end
        checks++;
        if ({seen, err_seen, cyc_at_done} !== 3'b110) begin
            failures++; $display("FAIL tmo_abort got seen/err/cyc=%b exp=110", {seen, err_seen, cyc_at_done});
        end
        checks++;
        if (stb_cnt !== TMO) begin
            failures++; $display("FAIL tmo_stb_cycles got=%0d exp=%0d", stb_cnt, TMO);
        end
    endtask

    task automatic test_bad_len(input logic [LW-1:0] len);
        send_cmd(1'b0, 32'h40, len);
        checks++;
        if ({done_o, err_o, m_wb_cyc_o, m_wb_stb_o, cmd_ready_o} !== 5'b11000) begin
            failures++; $display("FAIL badlen_%0d got done/err/cyc/stb/rdy=%b exp=11000", len,
                                 {done_o, err_o, m_wb_cyc_o, m_wb_stb_o, cmd_ready_o});
        end
        @(negedge wb_clk_i);
        checks++;
        if ({done_o, m_wb_cyc_o, cmd_ready_o} !== 3'b001) begin
            failures++; $display("FAIL badlen_%0d_idle got done/cyc/rdy=%b exp=001", len, {done_o, m_wb_cyc_o, cmd_ready_o});
        end
    endtask

    task automatic test_reset_mid_burst();
        send_cmd(1'b0, 32'h0, LW'(16));
        for (int i = 0; i < 3; i++) begin
            m_wb_ack_i = 1'b1;
            m_wb_dat_i = 32'h5000 + 32'(i);
            @(negedge wb_clk_i);
        end
        m_wb_ack_i = 1'b0;
        wb_rst_n_i = 1'b0;
        #1;
        checks++;
        if ({m_wb_cyc_o, m_wb_stb_o, done_o, rd_valid_o, m_wb_cti_o} !== 7'b0) begin
            failures++; $display("FAIL rst_mid got cyc/stb/done/rdv/cti=%b exp=0000000",
                                 {m_wb_cyc_o, m_wb_stb_o, done_o, rd_valid_o, m_wb_cti_o});
        end
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if ({cmd_ready_o, m_wb_cyc_o, done_o} !== 3'b100) begin
            failures++; $display("FAIL rst_release got rdy/cyc/done=%b exp=100", {cmd_ready_o, m_wb_cyc_o, done_o});
        end
    endtask

    task automatic test_back_to_back();
        send_cmd(1'b0, 32'h10B, LW'(2));
        checks++;
        if ({m_wb_adr_o, m_wb_cti_o} !== {32'h108, 3'b010}) begin
            failures++; $display("FAIL b2b_beat0 got adr=%h cti=%b exp adr=00000108 cti=010", m_wb_adr_o, m_wb_cti_o);
        end
        m_wb_ack_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if ({m_wb_adr_o, m_wb_cti_o} !== {32'h10C, 3'b111}) begin
            failures++; $display("FAIL b2b_beat1 got adr=%h cti=%b exp adr=0000010c cti=111", m_wb_adr_o, m_wb_cti_o);
        end
        @(negedge wb_clk_i);
        m_wb_ack_i = 1'b0;
        checks++;
        if ({done_o, err_o, m_wb_cyc_o} !== 3'b100) begin
            failures++; $display("FAIL b2b_done got done/err/cyc=%b exp=100", {done_o, err_o, m_wb_cyc_o});
        end
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 32'h500;
        cmd_len_i   = LW'(1);
        @(negedge wb_clk_i);
        checks++;
        if ({m_wb_cyc_o, cmd_ready_o} !== 2'b01) begin
            failures++; $display("FAIL b2b_idle_gap got cyc/rdy=%b exp=01", {m_wb_cyc_o, cmd_ready_o});
        end
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        checks++;
        if ({m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_adr_o} !== {2'b11, 3'b000, 32'h500}) begin
            failures++; $display("FAIL b2b_second got cyc/stb=%b cti=%b adr=%h exp 11 000 00000500",
                                 {m_wb_cyc_o, m_wb_stb_o}, m_wb_cti_o, m_wb_adr_o);
        end
        m_wb_ack_i = 1'b1;
        @(negedge wb_clk_i);
        m_wb_ack_i = 1'b0;
        checks++;
        if ({done_o, err_o} !== 2'b10) begin
            failures++; $display("FAIL b2b_second_done got done/err=%b exp=10", {done_o, err_o});
        end
    endtask

    initial begin
        repeat (2) @(negedge wb_clk_i);
        test_reset();
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        test_read_burst();
        test_write_single();
        test_write_gap();
        test_read_err();
        test_timeout();
        test_bad_len(LW'(0));
        test_bad_len(LW'(17));
        test_reset_mid_burst();
        test_back_to_back();
        repeat (2) @(negedge wb_clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
